// File: rtl/rob_retire_unit_pkg.sv
// Shared sizes, entry states and the reorder-buffer entry payload for rob_retire_unit.
package rob_retire_unit_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned RB_SIZE   = 8;
  localparam int unsigned RB_INDEX  = 3;
  localparam int unsigned REG_INDEX = 5;

  localparam logic [1:0] ST_FREE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]           state;
    logic                 is_store;
    logic [REG_INDEX-1:0] dest;
    logic [WORD_SIZE-1:0] data;
    logic [WORD_SIZE-1:0] addr;
  } rob_entry_t;

endpackage

// File: rtl/rob_slot_extract.sv
// Picks one WORD_SIZE word out of a flat per-slot CDB bus.
module rob_slot_extract
  import rob_retire_unit_pkg::*;
(
  input  logic [WORD_SIZE*RB_SIZE-1:0] bus,
  input  logic [RB_INDEX-1:0]          slot,
  output logic [WORD_SIZE-1:0]         word_c
);

  assign word_c = bus[slot*WORD_SIZE +: WORD_SIZE];

endmodule

// File: rtl/rob_retire_unit.sv
// Reorder buffer: allocates at tail, captures CDB results per slot, retires in order
// from head to the register writeback port or the handshaked store port.
module rob_retire_unit
  import rob_retire_unit_pkg::*;
(
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         alloc_req,
  input  logic                         alloc_is_store,
  input  logic [REG_INDEX-1:0]         alloc_dest,
  output logic                         alloc_ready,
  output logic [RB_INDEX-1:0]          alloc_index,
  input  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_data,
  input  logic [RB_SIZE-1:0]           CDB_data_valid,
  input  logic [WORD_SIZE*RB_SIZE-1:0] CDB_data_addr,
  output logic                         commit_valid,
  output logic [REG_INDEX-1:0]         commit_reg,
  output logic [WORD_SIZE-1:0]         commit_data,
  output logic                         store_valid,
  output logic [WORD_SIZE-1:0]         store_addr,
  output logic [WORD_SIZE-1:0]         store_data,
  input  logic                         store_ack
);

  localparam logic [RB_INDEX:0] RB_FULL = (RB_INDEX+1)'(RB_SIZE);

  rob_entry_t           entry_q [RB_SIZE];
  rob_entry_t           entry_d [RB_SIZE];
  logic [RB_INDEX-1:0]  head_q, head_d, tail_q, tail_d;
  logic [RB_INDEX:0]    count_q, count_d;
  logic                 alloc_ready_d;
  logic                 commit_valid_d, store_valid_d;
  logic [REG_INDEX-1:0] commit_reg_d;
  logic [WORD_SIZE-1:0] commit_data_d, store_addr_d, store_data_d;
  logic                 alloc_fire, retire;
  rob_entry_t           head_entry;
  logic [WORD_SIZE-1:0] cdb_data_w [RB_SIZE];
  logic [WORD_SIZE-1:0] cdb_addr_w [RB_SIZE];

  for (genvar g = 0; g < RB_SIZE; g++) begin : g_slot
    rob_slot_extract u_data (
      .bus    (CDB_data_data),
      .slot   (RB_INDEX'(g)),
      .word_c (cdb_data_w[g])
    );
    rob_slot_extract u_addr (
      .bus    (CDB_data_addr),
      .slot   (RB_INDEX'(g)),
      .word_c (cdb_addr_w[g])
    );
  end

  assign alloc_index = tail_q;

  // Next-state: capture, then retire from registered head, then allocate; flush overrides all.
  always_comb begin
    entry_d        = entry_q;
    head_d         = head_q;
    tail_d         = tail_q;
    count_d        = count_q;
    commit_valid_d = 1'b0;
    commit_reg_d   = commit_reg;
    commit_data_d  = commit_data;
    store_valid_d  = store_valid;
    store_addr_d   = store_addr;
    store_data_d   = store_data;
    retire         = 1'b0;
    alloc_fire     = alloc_req && alloc_ready;
    head_entry     = entry_q[head_q];

    for (int i = 0; i < RB_SIZE; i++) begin
      if (CDB_data_valid[i] && entry_q[i].state == ST_WAIT) begin
        entry_d[i].state = ST_DONE;
        entry_d[i].data  = cdb_data_w[i];
        entry_d[i].addr  = cdb_addr_w[i];
      end
    end

    if (store_valid) begin
      if (store_ack) begin
        store_valid_d = 1'b0;
        retire        = 1'b1;
      end
    end else if (head_entry.state == ST_DONE) begin
      if (head_entry.is_store) begin
        store_valid_d = 1'b1;
        store_addr_d  = head_entry.addr;
        store_data_d  = head_entry.data;
      end else begin
        commit_valid_d = 1'b1;
        commit_reg_d   = head_entry.dest;
        commit_data_d  = head_entry.data;
        retire         = 1'b1;
      end
    end

    if (retire) begin
      entry_d[head_q].state = ST_FREE;
      head_d                = head_q + RB_INDEX'(1);
    end

    if (alloc_fire) begin
      entry_d[tail_q].state    = ST_WAIT;
      entry_d[tail_q].is_store = alloc_is_store;
      entry_d[tail_q].dest     = alloc_dest;
      entry_d[tail_q].data     = '0;
      entry_d[tail_q].addr     = '0;
      tail_d                   = tail_q + RB_INDEX'(1);
    end

    case ({alloc_fire, retire})
      2'b10:   count_d = count_q + (RB_INDEX+1)'(1);
      2'b01:   count_d = count_q - (RB_INDEX+1)'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      for (int i = 0; i < RB_SIZE; i++) entry_d[i] = '0;
      head_d         = '0;
      tail_d         = '0;
      count_d        = '0;
      commit_valid_d = 1'b0;
      commit_reg_d   = '0;
      commit_data_d  = '0;
      store_valid_d  = 1'b0;
      store_addr_d   = '0;
      store_data_d   = '0;
    end

    alloc_ready_d = (count_d != RB_FULL);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RB_SIZE; i++) entry_q[i] <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      alloc_ready  <= 1'b1;
      commit_valid <= 1'b0;
      commit_reg   <= '0;
      commit_data  <= '0;
      store_valid  <= 1'b0;
      store_addr   <= '0;
      store_data   <= '0;
    end else begin
      entry_q      <= entry_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      alloc_ready  <= alloc_ready_d;
      commit_valid <= commit_valid_d;
      commit_reg   <= commit_reg_d;
      commit_data  <= commit_data_d;
      store_valid  <= store_valid_d;
      store_addr   <= store_addr_d;
      store_data   <= store_data_d;
    end
  end

endmodule

// File: tb/tb_rob_retire_unit.sv
// Directed, table-driven bench for rob_retire_unit with a hand-written async-reset-mid-store sequence.
module tb_rob_retire_unit;
  import rob_retire_unit_pkg::*;

  logic                         clk = 1'b0;
  logic                         reset = 1'b0;
  logic                         flush = 1'b0;
  logic                         alloc_req = 1'b0;
  logic                         alloc_is_store = 1'b0;
  logic [REG_INDEX-1:0]         alloc_dest = '0;
  logic                         alloc_ready;
  logic [RB_INDEX-1:0]          alloc_index;
  logic [WORD_SIZE*RB_SIZE-1:0] cdb_data = '0;
  logic [RB_SIZE-1:0]           cdb_valid = '0;
  logic [WORD_SIZE*RB_SIZE-1:0] cdb_addr = '0;
  logic                         commit_valid;
  logic [REG_INDEX-1:0]         commit_reg;
  logic [WORD_SIZE-1:0]         commit_data;
  logic                         store_valid;
  logic [WORD_SIZE-1:0]         store_addr;
  logic [WORD_SIZE-1:0]         store_data;
  logic                         store_ack = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  rob_retire_unit dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .alloc_req      (alloc_req),
    .alloc_is_store (alloc_is_store),
    .alloc_dest     (alloc_dest),
    .alloc_ready    (alloc_ready),
    .alloc_index    (alloc_index),
    .CDB_data_data  (cdb_data),
    .CDB_data_valid (cdb_valid),
    .CDB_data_addr  (cdb_addr),
    .commit_valid   (commit_valid),
    .commit_reg     (commit_reg),
    .commit_data    (commit_data),
    .store_valid    (store_valid),
    .store_addr     (store_addr),
    .store_data     (store_data),
    .store_ack      (store_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, al, st;
    logic [4:0]  dest;
    logic [7:0]  mask;
    logic [31:0] word, addr;
    logic        ack;
    logic        cv;
    logic [4:0]  cr;
    logic [31:0] cd;
    logic        sv;
    logic [31:0] sa, sd;
    logic        ar;
    logic [2:0]  ai;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic fl, al, st, input logic [4:0] dest,
                              input logic [7:0] mask, input logic [31:0] word, addr,
                              input logic ack, input logic cv, input logic [4:0] cr,
                              input logic [31:0] cd, input logic sv,
                              input logic [31:0] sa, sd, input logic ar,
                              input logic [2:0] ai);
    vec_t v;
    v.fl = fl; v.al = al; v.st = st; v.dest = dest; v.mask = mask; v.word = word;
    v.addr = addr; v.ack = ack; v.cv = cv; v.cr = cr; v.cd = cd; v.sv = sv;
    v.sa = sa; v.sd = sd; v.ar = ar; v.ai = ai;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic drive(input vec_t v);
    flush          = v.fl;
    alloc_req      = v.al;
    alloc_is_store = v.st;
    alloc_dest     = v.dest;
    cdb_valid      = v.mask;
    cdb_data       = {RB_SIZE{v.word}};
    cdb_addr       = {RB_SIZE{v.addr}};
    store_ack      = v.ack;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    chk($sformatf("v%0d commit_valid", idx), 32'(commit_valid), 32'(v.cv));
    chk($sformatf("v%0d store_valid", idx), 32'(store_valid), 32'(v.sv));
    chk($sformatf("v%0d alloc_ready", idx), 32'(alloc_ready), 32'(v.ar));
    chk($sformatf("v%0d alloc_index", idx), 32'(alloc_index), 32'(v.ai));
    if (v.cv) begin
      chk($sformatf("v%0d commit_reg", idx), 32'(commit_reg), 32'(v.cr));
      chk($sformatf("v%0d commit_data", idx), commit_data, v.cd);
    end
    if (v.sv) begin
      chk($sformatf("v%0d store_addr", idx), store_addr, v.sa);
      chk($sformatf("v%0d store_data", idx), store_data, v.sd);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " commit_valid"}, 32'(commit_valid), 32'd0);
    chk({nm, " commit_reg"}, 32'(commit_reg), 32'd0);
    chk({nm, " commit_data"}, commit_data, 32'd0);
    chk({nm, " store_valid"}, 32'(store_valid), 32'd0);
    chk({nm, " store_addr"}, store_addr, 32'd0);
    chk({nm, " store_data"}, store_data, 32'd0);
    chk({nm, " alloc_ready"}, 32'(alloc_ready), 32'd1);
    chk({nm, " alloc_index"}, 32'(alloc_index), 32'd0);
  endtask

  initial begin
    // In-order commit: younger result first, older later
    vq.push_back(mk(0,1,0, 3, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,1));
    vq.push_back(mk(0,1,0, 4, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,2));
    vq.push_back(mk(0,0,0, 0, 8'h02, 32'h22, 0, 0,  0,0,0,  0,0,0, 1,2));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,2));
    vq.push_back(mk(0,0,0, 0, 8'h01, 32'h11, 0, 0,  0,0,0,  0,0,0, 1,2));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  1,3,32'h11,  0,0,0, 1,2));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  1,4,32'h22,  0,0,0, 1,2));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,2));
    // Store held for three cycles, then acked; ALU entry behind it commits next
    vq.push_back(mk(0,1,1, 0, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,3));
    vq.push_back(mk(0,1,0, 7, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,4));
    vq.push_back(mk(0,0,0, 0, 8'h04, 32'hAB, 32'h100, 0,  0,0,0,  0,0,0, 1,4));
    vq.push_back(mk(0,0,0, 0, 8'h08, 32'h77, 0, 0,  0,0,0,  1,32'h100,32'hAB, 1,4));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  0,0,0,  1,32'h100,32'hAB, 1,4));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  0,0,0,  1,32'h100,32'hAB, 1,4));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 1,  0,0,0,  0,0,0, 1,4));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  1,7,32'h77,  0,0,0, 1,4));
    // Strobe on FREE head slot, repeated strobe on a DONE slot
    vq.push_back(mk(0,0,0, 0, 8'h10, 32'h99, 0, 0,  0,0,0,  0,0,0, 1,4));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,4));
    vq.push_back(mk(0,1,0, 9, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,5));
    vq.push_back(mk(0,1,0, 10, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,6));
    vq.push_back(mk(0,0,0, 0, 8'h20, 32'h55, 0, 0,  0,0,0,  0,0,0, 1,6));
    vq.push_back(mk(0,0,0, 0, 8'h20, 32'h66, 0, 0,  0,0,0,  0,0,0, 1,6));
    vq.push_back(mk(0,0,0, 0, 8'h10, 32'h44, 0, 0,  0,0,0,  0,0,0, 1,6));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  1,9,32'h44,  0,0,0, 1,6));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  1,10,32'h55,  0,0,0, 1,6));
    // Walk pointers across the wrap back to 0
    vq.push_back(mk(0,1,0, 11, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,7));
    vq.push_back(mk(0,1,0, 12, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,0));
    vq.push_back(mk(0,0,0, 0, 8'h40, 32'h61, 0, 0,  0,0,0,  0,0,0, 1,0));
    vq.push_back(mk(0,0,0, 0, 8'h80, 32'h62, 0, 0,  1,11,32'h61,  0,0,0, 1,0));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  1,12,32'h62,  0,0,0, 1,0));
    // Fill all eight entries
    for (int k = 0; k < 8; k++)
      vq.push_back(mk(0,1,0, 5'(k+1), 8'h00, 0, 0, 0,  0,0,0,  0,0,0, (k < 7), 3'(k+1)));
    vq.push_back(mk(0,1,0, 20, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 0,0));
    vq.push_back(mk(0,0,0, 0, 8'h01, 32'hA0, 0, 0,  0,0,0,  0,0,0, 0,0));
    vq.push_back(mk(0,1,0, 21, 8'h00, 0, 0, 0,  1,1,32'hA0,  0,0,0, 1,0));
    vq.push_back(mk(0,1,0, 21, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 0,1));
    // Retire three, leaving five live, then flush against an alloc
    vq.push_back(mk(0,0,0, 0, 8'h0E, 32'hB0, 0, 0,  0,0,0,  0,0,0, 0,1));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  1,2,32'hB0,  0,0,0, 1,1));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  1,3,32'hB0,  0,0,0, 1,1));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  1,4,32'hB0,  0,0,0, 1,1));
    vq.push_back(mk(1,1,0, 5, 8'h10, 32'hC0, 0, 0,  0,0,0,  0,0,0, 1,0));
    vq.push_back(mk(0,0,0, 0, 8'hFF, 32'hD0, 0, 0,  0,0,0,  0,0,0, 1,0));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,0));
    vq.push_back(mk(0,1,0, 6, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,1));
    // Flush drops a pending store; a late ack does nothing
    vq.push_back(mk(1,0,0, 0, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,0));
    vq.push_back(mk(0,1,1, 0, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,1));
    vq.push_back(mk(0,0,0, 0, 8'h01, 32'h5A, 32'h200, 0,  0,0,0,  0,0,0, 1,1));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 0,  0,0,0,  1,32'h200,32'h5A, 1,1));
    vq.push_back(mk(1,0,0, 0, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 1,0));
    vq.push_back(mk(0,0,0, 0, 8'h00, 0, 0, 1,  0,0,0,  0,0,0, 1,0));

    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

    // Async reset while a store is pending
    @(negedge clk);
    drive(mk(0,1,1, 0, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 0,0));
    @(negedge clk);
    drive(mk(0,0,0, 0, 8'h01, 32'hAB, 32'h100, 0,  0,0,0,  0,0,0, 0,0));
    @(negedge clk);
    drive(mk(0,0,0, 0, 8'h00, 0, 0, 0,  0,0,0,  0,0,0, 0,0));
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      if (store_valid) break;
    end
    chk("midstore store_valid", 32'(store_valid), 32'd1);
    chk("midstore store_addr", store_addr, 32'h100);
    #2;
    reset = 1'b1;
    #1;
    chk_all_zero("async reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("post reset store_valid", 32'(store_valid), 32'd0);
    chk("post reset commit_valid", 32'(commit_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
